// File: rtl/aemb_pkg.sv
// Shared encodings for the AEMB memory/writeback stage: access sizes, FSM
// states, byte-lane select patterns and the lane-select helper.
package aemb_pkg;

   // Access size carried with every load/store
   typedef enum logic [1:0] {
      SzByte = 2'b00,
      SzHalf = 2'b01,
      SzWord = 2'b10
   } size_e;

   // Memory-stage sequencer states
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBus  = 2'b01,
      StWb   = 2'b10
   } state_e;

   // Big-endian lane selects: bit 3 of sel is bus bits [31:24]
   localparam logic [3:0] SelByte0  = 4'b1000;
   localparam logic [3:0] SelHalfHi = 4'b1100;
   localparam logic [3:0] SelHalfLo = 4'b0011;
   localparam logic [3:0] SelWord   = 4'b1111;

   // Width of the bus-cycle timeout counter
   localparam int unsigned CntW = 8;

   // Lane select for a given size and byte offset; offset bits below the
   // access size are ignored. The unused size encoding behaves as a word.
   function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] off);
      logic [3:0] sel;
      case (sz)
         SzByte:  sel = SelByte0 >> off;
         SzHalf:  sel = off[1] ? SelHalfLo : SelHalfHi;
         default: sel = SelWord;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/aemb_lane.sv
// Byte-lane steering for the data bus: lane select, store-data replication
// and load-data extraction with zero extension (big-endian lane order).
module aemb_lane
   import aemb_pkg::*;
(
   input  logic [1:0]  sz,
   input  logic [1:0]  off,
   input  logic [31:0] st_dat,
   input  logic [31:0] bus_dat,
   output logic [3:0]  sel,
   output logic [31:0] wr_dat,
   output logic [31:0] ld_dat
);

   // Lane select straight from the shared helper
   always_comb begin
      sel = lane_sel(sz, off);
   end

   // Replicate store data so every selected lane carries the right bytes
   always_comb begin
      wr_dat = st_dat;
      case (sz)
         SzByte:  wr_dat = {4{st_dat[7:0]}};
         SzHalf:  wr_dat = {2{st_dat[15:0]}};
         default: wr_dat = st_dat;
      endcase
   end

   // Pull the addressed lane down to bit 0 and zero-extend
   always_comb begin
      ld_dat = '0;
      case (sz)
         SzByte: begin
            unique case (off)
               2'd0: ld_dat[7:0] = bus_dat[31:24];
               2'd1: ld_dat[7:0] = bus_dat[23:16];
               2'd2: ld_dat[7:0] = bus_dat[15:8];
               2'd3: ld_dat[7:0] = bus_dat[7:0];
            endcase
         end
         SzHalf:  ld_dat[15:0] = off[1] ? bus_dat[15:0] : bus_dat[31:16];
         default: ld_dat = bus_dat;
      endcase
   end

endmodule

// File: rtl/aemb_memwb.sv
// AEMB memory/writeback stage: captures the execute result, runs one data-bus
// cycle for loads/stores (with timeout), and drives register-file writeback.
module aemb_memwb
   import aemb_pkg::*;
#(
   parameter int unsigned BUS_TMO = 16
) (
   input  logic        gclk,
   input  logic        grst,
   input  logic        gena,
   input  logic [31:0] x_alu,
   input  logic [31:0] x_opd,
   input  logic [4:0]  x_rd,
   input  logic        x_ld,
   input  logic        x_st,
   input  logic        x_wr,
   input  logic [1:0]  x_sz,
   output logic [29:0] dwb_adr_o,
   output logic [31:0] dwb_dat_o,
   output logic [3:0]  dwb_sel_o,
   output logic        dwb_stb_o,
   output logic        dwb_wre_o,
   input  logic [31:0] dwb_dat_i,
   input  logic        dwb_ack_i,
   output logic [31:0] m_alu,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_dat,
   output logic        m_stall,
   output logic        m_berr
);

   // Last count value before the bus cycle is abandoned
   localparam logic [CntW-1:0] TmoLast = CntW'(BUS_TMO - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       alu_q, opd_q, rf_dat_q;
   logic [4:0]        rd_q;
   logic [1:0]        sz_q;
   logic              ld_q, st_q;
   logic              rf_we_q, berr_q;

   logic              capture, mem_req, in_bus, timeout, bus_ack;
   logic [3:0]        lane_sel_w;
   logic [31:0]       lane_wdat, lane_rdat;

   assign in_bus  = (state_q == StBus);
   assign mem_req = x_ld | x_st;
   // The pipeline only hands over a new instruction while the stage is idle
   assign capture = gena & (state_q == StIdle);
   // Ack is only meaningful inside a bus cycle
   assign bus_ack = in_bus & dwb_ack_i;

   aemb_lane u_lane (
      .sz      (sz_q),
      .off     (alu_q[1:0]),
      .st_dat  (opd_q),
      .bus_dat (dwb_dat_i),
      .sel     (lane_sel_w),
      .wr_dat  (lane_wdat),
      .ld_dat  (lane_rdat)
   );

   // Next-state and timeout counter; ack wins over a coinciding timeout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timeout = 1'b0;
      case (state_q)
         StIdle: begin
            if (capture && mem_req) begin
               state_d = StBus;
               cnt_d   = '0;
            end
         end
         StBus: begin
            if (dwb_ack_i) begin
               state_d = StWb;
               cnt_d   = '0;
            end else if (cnt_q == TmoLast) begin
               state_d = StWb;
               cnt_d   = '0;
               timeout = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWb: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM state and bus-cycle counter
   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Captured instruction fields; only change on an idle-state capture
   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         alu_q <= '0;
         opd_q <= '0;
         rd_q  <= '0;
         sz_q  <= SzByte;
         ld_q  <= 1'b0;
         st_q  <= 1'b0;
      end else if (capture) begin
         alu_q <= x_alu;
         opd_q <= x_opd;
         rd_q  <= x_rd;
         sz_q  <= x_sz;
         ld_q  <= x_ld;
         st_q  <= x_st;
      end
   end

   // Writeback strobe, data and bus-error pulse; strobes self-clear each cycle
   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         rf_we_q  <= 1'b0;
         rf_dat_q <= '0;
         berr_q   <= 1'b0;
      end else begin
         rf_we_q <= 1'b0;
         berr_q  <= timeout;
         if (capture && !mem_req) begin
            rf_dat_q <= x_alu;
            rf_we_q  <= x_wr && (x_rd != 5'd0);
         end
         if (bus_ack && ld_q) begin
            rf_dat_q <= lane_rdat;
            rf_we_q  <= (rd_q != 5'd0);
         end
      end
   end

   // Bus and pipeline outputs; bus controls are gated so they idle at zero
   always_comb begin
      dwb_stb_o = in_bus;
      dwb_wre_o = in_bus & st_q;
      dwb_sel_o = in_bus ? lane_sel_w : 4'b0000;
      dwb_adr_o = alu_q[31:2];
      dwb_dat_o = lane_wdat;
      m_alu     = alu_q;
      rf_we     = rf_we_q;
      rf_rd     = rd_q;
      rf_dat    = rf_dat_q;
      m_berr    = berr_q;
      m_stall   = grst & (in_bus | (capture & mem_req));
   end

endmodule

// File: tb/tb_aemb_memwb.sv
// Self-checking bench for aemb_memwb: scoreboard of expected writebacks plus
// per-scenario inline checks of bus signalling, stall and error behaviour.
module tb_aemb_memwb;

   localparam int unsigned TMO = 5;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] dat;
   } wb_t;

   typedef struct {
      int          stb_n;
      int          stall_n;
      int          berr_n;
      int          we_n;
      logic [3:0]  sel;
      logic [31:0] wdat;
      logic [29:0] adr;
      logic        wre;
      logic        stable;
   } bus_res_t;

   logic        gclk, grst, gena;
   logic [31:0] x_alu, x_opd;
   logic [4:0]  x_rd;
   logic        x_ld, x_st, x_wr;
   logic [1:0]  x_sz;
   logic [29:0] dwb_adr_o;
   logic [31:0] dwb_dat_o, dwb_dat_i;
   logic [3:0]  dwb_sel_o;
   logic        dwb_stb_o, dwb_wre_o, dwb_ack_i;
   logic [31:0] m_alu, rf_dat;
   logic        rf_we, m_stall, m_berr;
   logic [4:0]  rf_rd;

   int  compared   = 0;
   int  mismatched = 0;
   wb_t exp_q[$];
   wb_t obs_q[$];

   aemb_memwb #(.BUS_TMO(TMO)) dut (
      .gclk      (gclk),
      .grst      (grst),
      .gena      (gena),
      .x_alu     (x_alu),
      .x_opd     (x_opd),
      .x_rd      (x_rd),
      .x_ld      (x_ld),
      .x_st      (x_st),
      .x_wr      (x_wr),
      .x_sz      (x_sz),
      .dwb_adr_o (dwb_adr_o),
      .dwb_dat_o (dwb_dat_o),
      .dwb_sel_o (dwb_sel_o),
      .dwb_stb_o (dwb_stb_o),
      .dwb_wre_o (dwb_wre_o),
      .dwb_dat_i (dwb_dat_i),
      .dwb_ack_i (dwb_ack_i),
      .m_alu     (m_alu),
      .rf_we     (rf_we),
      .rf_rd     (rf_rd),
      .rf_dat    (rf_dat),
      .m_stall   (m_stall),
      .m_berr    (m_berr)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   // Record every writeback the DUT produces
   always @(negedge gclk) begin
      if (grst === 1'b1 && rf_we === 1'b1) obs_q.push_back({rf_rd, rf_dat});
   end

   task automatic quiet();
      gena = 1'b0; x_ld = 1'b0; x_st = 1'b0; x_wr = 1'b0;
   endtask

   task automatic issue(input logic [31:0] alu, input logic [31:0] opd, input logic [4:0] rd,
                        input logic ld, input logic st, input logic wr, input logic [1:0] sz);
      x_alu = alu; x_opd = opd; x_rd = rd; x_ld = ld; x_st = st; x_wr = wr; x_sz = sz;
      gena = 1'b1;
   endtask

   // Called right after issue(); runs the bus cycle, acking in BUS cycle ack_at
   // (0 = never), and measures what the DUT did. Ends on a negedge in IDLE.
   task automatic run_bus(input int ack_at, input logic [31:0] rdat, output bus_res_t r);
      r.stb_n = 0; r.stall_n = 0; r.berr_n = 0; r.we_n = 0; r.stable = 1'b1;
      r.sel = '0; r.wdat = '0; r.adr = '0; r.wre = 1'b0;
      @(negedge gclk);
      if (m_stall) r.stall_n++;
      @(posedge gclk); #1;
      quiet();
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (cyc == ack_at) begin
            dwb_ack_i = 1'b1; dwb_dat_i = rdat;
         end
         @(negedge gclk);
         if (m_stall) r.stall_n++;
         if (m_berr) r.berr_n++;
         if (rf_we) r.we_n++;
         if (!dwb_stb_o) break;
         if (r.stb_n == 0) begin
            r.sel = dwb_sel_o; r.wdat = dwb_dat_o; r.adr = dwb_adr_o; r.wre = dwb_wre_o;
         end else if ({r.sel, r.wdat, r.adr, r.wre} !==
                      {dwb_sel_o, dwb_dat_o, dwb_adr_o, dwb_wre_o}) begin
            r.stable = 1'b0;
         end
         r.stb_n++;
         @(posedge gclk); #1;
         dwb_ack_i = 1'b0; dwb_dat_i = '0;
      end
      dwb_ack_i = 1'b0; dwb_dat_i = '0;
      @(posedge gclk); #1;
      @(negedge gclk);
      if (m_stall) r.stall_n++;
      if (m_berr) r.berr_n++;
      if (rf_we) r.we_n++;
   endtask

   task automatic test_reset();
      grst = 1'b0; dwb_ack_i = 1'b0; dwb_dat_i = '0; x_alu = '0; x_opd = '0; x_rd = '0;
      x_sz = 2'b00; quiet();
      x_ld = 1'b1; gena = 1'b1;
      @(negedge gclk);
      compared++;
      if ({dwb_stb_o, dwb_wre_o, dwb_sel_o, rf_we, m_berr, m_stall} !== 9'd0) begin
         mismatched++;
         $display("FAIL reset_ctl: got stb/wre/sel/we/berr/stall=%b, required 0",
                  {dwb_stb_o, dwb_wre_o, dwb_sel_o, rf_we, m_berr, m_stall});
      end
      compared++;
      if (m_alu !== 32'd0) begin
         mismatched++; $display("FAIL reset_m_alu: got %h, required 00000000", m_alu);
      end
      compared++;
      if (rf_dat !== 32'd0) begin
         mismatched++; $display("FAIL reset_rf_dat: got %h, required 00000000", rf_dat);
      end
      compared++;
      if (rf_rd !== 5'd0) begin
         mismatched++; $display("FAIL reset_rf_rd: got %0d, required 0", rf_rd);
      end
      @(negedge gclk);
      quiet();
      grst = 1'b1;
   endtask

   task automatic test_alu_wb();
      wb_t o, e;
      @(posedge gclk); #1;
      issue(32'h12345678, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 2'b10);
      exp_q.push_back({5'd3, 32'h12345678});
      @(negedge gclk);
      compared++;
      if (m_stall !== 1'b0) begin
         mismatched++; $display("FAIL alu_stall_pending: got %b, required 0", m_stall);
      end
      @(posedge gclk); #1;
      quiet();
      @(negedge gclk);
      compared++;
      if ({rf_we, rf_rd, rf_dat, m_stall} !== {1'b1, 5'd3, 32'h12345678, 1'b0}) begin
         mismatched++;
         $display("FAIL alu_wb: got we=%b rd=%0d dat=%h stall=%b, required 1 3 12345678 0",
                  rf_we, rf_rd, rf_dat, m_stall);
      end
      compared++;
      if (m_alu !== 32'h12345678) begin
         mismatched++; $display("FAIL alu_m_alu: got %h, required 12345678", m_alu);
      end
      @(negedge gclk);
      compared++;
      if (rf_we !== 1'b0) begin
         mismatched++; $display("FAIL alu_we_pulse: got %b one cycle later, required 0", rf_we);
      end
      @(posedge gclk); #1;
      compared++;
      if (obs_q.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL alu_wb_count: got %0d, required %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
         if (o !== e) begin
            mismatched++;
            $display("FAIL alu_wb_sb: got rd=%0d dat=%h, required rd=%0d dat=%h",
                     o.rd, o.dat, e.rd, e.dat);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      wb_t o, e;
      logic [31:0] vals [3];
      vals[0] = 32'hA0000001; vals[1] = 32'hB0000002; vals[2] = 32'hC0000003;
      for (int i = 0; i < 3; i++) begin
         @(posedge gclk); #1;
         issue(vals[i], 32'd0, 5'(i + 10), 1'b0, 1'b0, 1'b1, 2'b10);
         exp_q.push_back({5'(i + 10), vals[i]});
      end
      @(posedge gclk); #1;
      // gena low: these fields must not be captured
      quiet();
      x_alu = 32'hDEAD0000; x_rd = 5'd4; x_wr = 1'b1;
      @(negedge gclk);
      compared++;
      if (m_alu !== vals[2]) begin
         mismatched++; $display("FAIL b2b_m_alu: got %h, required %h", m_alu, vals[2]);
      end
      @(posedge gclk); #1;
      @(negedge gclk);
      compared++;
      if ({m_alu, rf_we} !== {vals[2], 1'b0}) begin
         mismatched++;
         $display("FAIL gena_hold: got m_alu=%h we=%b, required %h 0", m_alu, rf_we, vals[2]);
      end
      @(posedge gclk); #1;
      compared++;
      if (obs_q.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL b2b_wb_count: got %0d, required %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
         if (o !== e) begin
            mismatched++;
            $display("FAIL b2b_wb_sb: got rd=%0d dat=%h, required rd=%0d dat=%h",
                     o.rd, o.dat, e.rd, e.dat);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_byte_load();
      bus_res_t r;
      wb_t o, e;
      @(posedge gclk); #1;
      issue(32'h00001001, 32'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b00);
      exp_q.push_back({5'd5, 32'h000000BB});
      run_bus(3, 32'hAABBCCDD, r);
      compared++;
      if ({r.sel, r.wre, r.adr} !== {4'b0100, 1'b0, 30'h400}) begin
         mismatched++;
         $display("FAIL bload_bus: got sel=%b wre=%b adr=%h, required 0100 0 00000400",
                  r.sel, r.wre, r.adr);
      end
      compared++;
      if (r.stall_n != 4 || r.stb_n != 3) begin
         mismatched++;
         $display("FAIL bload_stall: got stall=%0d stb=%0d, required 4 3", r.stall_n, r.stb_n);
      end
      compared++;
      if (r.stable !== 1'b1 || r.berr_n != 0) begin
         mismatched++;
         $display("FAIL bload_stable: got stable=%b berr=%0d, required 1 0", r.stable, r.berr_n);
      end
      @(posedge gclk); #1;
      compared++;
      if (obs_q.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL bload_wb_count: got %0d, required %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
         if (o !== e) begin
            mismatched++;
            $display("FAIL bload_wb_sb: got rd=%0d dat=%h, required rd=%0d dat=%h",
                     o.rd, o.dat, e.rd, e.dat);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_half_store();
      bus_res_t r;
      @(posedge gclk); #1;
      issue(32'h00002002, 32'h0000BEEF, 5'd7, 1'b0, 1'b1, 1'b0, 2'b01);
      run_bus(2, 32'hFFFFFFFF, r);
      compared++;
      if ({r.sel, r.wdat, r.wre, r.adr} !== {4'b0011, 32'hBEEFBEEF, 1'b1, 30'h800}) begin
         mismatched++;
         $display("FAIL hstore_bus: got sel=%b dat=%h wre=%b adr=%h, required 0011 BEEFBEEF 1 800",
                  r.sel, r.wdat, r.wre, r.adr);
      end
      compared++;
      if (r.we_n != 0 || r.stb_n != 2 || r.stable !== 1'b1) begin
         mismatched++;
         $display("FAIL hstore_ctl: got we=%0d stb=%0d stable=%b, required 0 2 1",
                  r.we_n, r.stb_n, r.stable);
      end
      @(posedge gclk); #1;
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++; $display("FAIL hstore_wb_count: got %0d, required 0", obs_q.size());
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_lanes();
      bus_res_t r;
      wb_t o, e;
      logic [3:0]  bsel [4];
      logic [7:0]  bval [4];
      bsel[0] = 4'b1000; bsel[1] = 4'b0100; bsel[2] = 4'b0010; bsel[3] = 4'b0001;
      bval[0] = 8'h11; bval[1] = 8'h22; bval[2] = 8'h33; bval[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         @(posedge gclk); #1;
         issue(32'h100 + 32'(i), 32'h0000005A, 5'd1, 1'b0, 1'b1, 1'b0, 2'b00);
         run_bus(1, 32'd0, r);
         compared++;
         if ({r.sel, r.wdat} !== {bsel[i], 32'h5A5A5A5A}) begin
            mismatched++;
            $display("FAIL bstore_lane%0d: got sel=%b dat=%h, required %b 5A5A5A5A",
                     i, r.sel, r.wdat, bsel[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge gclk); #1;
         issue(32'h200 + 32'(i), 32'd0, 5'(i + 1), 1'b1, 1'b0, 1'b1, 2'b00);
         exp_q.push_back({5'(i + 1), 24'd0, bval[i]});
         run_bus(1, 32'h11223344, r);
         compared++;
         if (r.sel !== bsel[i]) begin
            mismatched++;
            $display("FAIL bload_lane%0d: got sel=%b, required %b", i, r.sel, bsel[i]);
         end
      end
      // Word ignores offset bits 1:0
      @(posedge gclk); #1;
      issue(32'h00003003, 32'd0, 5'd12, 1'b1, 1'b0, 1'b1, 2'b10);
      exp_q.push_back({5'd12, 32'hCAFEF00D});
      run_bus(2, 32'hCAFEF00D, r);
      compared++;
      if ({r.sel, r.adr} !== {4'b1111, 30'hC00}) begin
         mismatched++;
         $display("FAIL wload_bus: got sel=%b adr=%h, required 1111 C00", r.sel, r.adr);
      end
      // Half ignores offset bit 0, both halves
      @(posedge gclk); #1;
      issue(32'h00004003, 32'd0, 5'd13, 1'b1, 1'b0, 1'b1, 2'b01);
      exp_q.push_back({5'd13, 32'h0000F00D});
      run_bus(1, 32'hCAFEF00D, r);
      compared++;
      if (r.sel !== 4'b0011) begin
         mismatched++; $display("FAIL hload_lo_sel: got %b, required 0011", r.sel);
      end
      @(posedge gclk); #1;
      issue(32'h00004001, 32'd0, 5'd14, 1'b1, 1'b0, 1'b1, 2'b01);
      exp_q.push_back({5'd14, 32'h0000CAFE});
      run_bus(1, 32'hCAFEF00D, r);
      compared++;
      if (r.sel !== 4'b1100) begin
         mismatched++; $display("FAIL hload_hi_sel: got %b, required 1100", r.sel);
      end
      @(posedge gclk); #1;
      compared++;
      if (obs_q.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL lanes_wb_count: got %0d, required %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
         if (o !== e) begin
            mismatched++;
            $display("FAIL lanes_wb_sb: got rd=%0d dat=%h, required rd=%0d dat=%h",
                     o.rd, o.dat, e.rd, e.dat);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_timeout();
      bus_res_t r;
      wb_t o, e;
      @(posedge gclk); #1;
      issue(32'h00005000, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b10);
      run_bus(0, 32'd0, r);
      compared++;
      if (r.stb_n != TMO || r.berr_n != 1 || r.we_n != 0) begin
         mismatched++;
         $display("FAIL timeout: got stb=%0d berr=%0d we=%0d, required %0d 1 0",
                  r.stb_n, r.berr_n, r.we_n, TMO);
      end
      compared++;
      if (r.stall_n != TMO + 1) begin
         mismatched++;
         $display("FAIL timeout_stall: got %0d, required %0d", r.stall_n, TMO + 1);
      end
      // Back in IDLE: an ALU op must be accepted immediately
      @(posedge gclk); #1;
      issue(32'h55AA55AA, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1, 2'b10);
      exp_q.push_back({5'd2, 32'h55AA55AA});
      @(posedge gclk); #1;
      quiet();
      // Ack in the final BUS cycle still counts as success
      @(posedge gclk); #1;
      issue(32'h00005004, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1, 2'b10);
      exp_q.push_back({5'd8, 32'h0BADF00D});
      run_bus(TMO, 32'h0BADF00D, r);
      compared++;
      if (r.stb_n != TMO || r.berr_n != 0 || r.we_n != 1) begin
         mismatched++;
         $display("FAIL ack_at_tmo: got stb=%0d berr=%0d we=%0d, required %0d 0 1",
                  r.stb_n, r.berr_n, r.we_n, TMO);
      end
      @(posedge gclk); #1;
      compared++;
      if (obs_q.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL tmo_wb_count: got %0d, required %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
         if (o !== e) begin
            mismatched++;
            $display("FAIL tmo_wb_sb: got rd=%0d dat=%h, required rd=%0d dat=%h",
                     o.rd, o.dat, e.rd, e.dat);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid_bus();
      int stb_seen;
      @(posedge gclk); #1;
      issue(32'h00006000, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 2'b10);
      @(posedge gclk); #1;
      quiet();
      @(posedge gclk); #1;
      @(negedge gclk);
      compared++;
      if (dwb_stb_o !== 1'b1) begin
         mismatched++; $display("FAIL rst_bus_pre: got stb=%b, required 1", dwb_stb_o);
      end
      #2 grst = 1'b0;
      #1;
      compared++;
      if ({dwb_stb_o, dwb_sel_o, m_stall, m_alu} !== 38'd0) begin
         mismatched++;
         $display("FAIL rst_async: got stb=%b sel=%b stall=%b m_alu=%h, required all 0",
                  dwb_stb_o, dwb_sel_o, m_stall, m_alu);
      end
      // Ack during and just after reset must be ignored
      dwb_ack_i = 1'b1; dwb_dat_i = 32'hFFFFFFFF;
      @(posedge gclk);
      @(negedge gclk);
      grst = 1'b1;
      @(posedge gclk); #1;
      dwb_ack_i = 1'b0; dwb_dat_i = '0;
      stb_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge gclk);
         if (dwb_stb_o) stb_seen++;
      end
      compared++;
      if (stb_seen != 0) begin
         mismatched++; $display("FAIL rst_resume_idle: got %0d stb cycles, required 0", stb_seen);
      end
      @(posedge gclk); #1;
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++; $display("FAIL rst_wb_count: got %0d, required 0", obs_q.size());
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_r0();
      bus_res_t r;
      @(posedge gclk); #1;
      issue(32'h00007000, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1, 2'b10);
      run_bus(2, 32'h87654321, r);
      compared++;
      if (r.we_n != 0 || r.stb_n != 2) begin
         mismatched++;
         $display("FAIL r0_load: got we=%0d stb=%0d, required 0 2", r.we_n, r.stb_n);
      end
      @(posedge gclk); #1;
      issue(32'h13572468, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10);
      @(posedge gclk); #1;
      quiet();
      @(negedge gclk);
      compared++;
      if (rf_we !== 1'b0) begin
         mismatched++; $display("FAIL r0_alu: got we=%b, required 0", rf_we);
      end
      @(posedge gclk); #1;
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++; $display("FAIL r0_wb_count: got %0d, required 0", obs_q.size());
      end
      obs_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_alu_wb();
      test_back_to_back();
      test_byte_load();
      test_half_store();
      test_lanes();
      test_timeout();
      test_reset_mid_bus();
      test_r0();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
